// File: rtl/obi2hci_bridge_pkg.sv
// Bridge-local definitions: FSM state encoding.
// Ports: none (package).
// IDLE = nothing outstanding, FWD = HCI transactions outstanding, ERR = error response pending.
package obi2hci_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_ERR  = 2'd2
  } obi2hci_state_e;

endpackage

// File: rtl/redmule_tile_pkg.sv
// Shared tile-level types and constants: OBI/HCI data-port structs, L1 window, outstanding limit.
// Ports: none (package).
// Types are packed so they can travel as single buses between tile components.
package redmule_tile_pkg;

  localparam int unsigned N_MAX_TRAN = 1;
  localparam logic [31:0] L1_ADDR_START = 32'h1000_0000;
  localparam logic [31:0] L1_ADDR_END   = 32'h1002_0000;
  localparam int unsigned AID_W = 4;

  // Read data returned with an error response for accesses outside the L1 window.
  localparam logic [31:0] OBI2HCI_ERR_RDATA = 32'hBADC_AB1E;

  typedef struct packed {
    logic [31:0]      addr;
    logic             we;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic [AID_W-1:0] aid;
  } core_obi_a_t;

  typedef struct packed {
    logic        req;
    core_obi_a_t a;
  } core_data_req_t;

  typedef struct packed {
    logic [31:0]      rdata;
    logic [AID_W-1:0] rid;
    logic             err;
  } core_obi_r_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    core_obi_r_t r;
  } core_data_rsp_t;

  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic        r_ready;
    logic [1:0]  user;
    logic [6:0]  ecc;
  } core_hci_data_req_t;

  typedef struct packed {
    logic        gnt;
    logic        r_valid;
    logic [31:0] r_data;
  } core_hci_data_rsp_t;

endpackage

// File: rtl/obi2hci_id_fifo.sv
// In-order ID FIFO remembering the aid of every forwarded transaction.
// Latency: head visible combinationally once written; push+pop allowed at any occupancy, even full.
// Ports: clk_i/rst_ni, push_i+data_i, pop_i, full_o/empty_o, head_o, count_o (occupancy).
module obi2hci_id_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign head_o  = r_mem[r_rptr];
  assign count_o = r_count;

  // At full, a push is only accepted alongside a pop: the slot being written is the one being freed.
  assign w_push = push_i && (!full_o || pop_i);
  assign w_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_next(r_wptr);
      if (w_pop)  r_rptr <= ptr_next(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/obi2hci_bridge.sv
// OBI subordinate to HCI initiator bridge; out-of-window accesses answered locally with an error.
// Latency: grant combinational from HCI gnt, response forwarded in the r_valid cycle; errors respond 1 cycle after grant.
// Ports: clk_i, rst_ni, obi_req_i/obi_rsp_o (core side), hci_req_o/hci_rsp_i (memory side), busy_o.
module obi2hci_bridge
  import redmule_tile_pkg::*;
  import obi2hci_bridge_pkg::*;
#(
  parameter int unsigned MAX_OUTST  = N_MAX_TRAN + 1,
  parameter logic [31:0] ADDR_START = L1_ADDR_START,
  parameter logic [31:0] ADDR_END   = L1_ADDR_END
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  core_data_req_t     obi_req_i,
  output core_data_rsp_t     obi_rsp_o,
  output core_hci_data_req_t hci_req_o,
  input  core_hci_data_rsp_t hci_rsp_i,
  output logic               busy_o
);

  localparam int unsigned CW = $clog2(MAX_OUTST + 1);

  obi2hci_state_e   r_state;
  logic             r_err_pend;
  logic [AID_W-1:0] r_err_aid;

  logic             w_in_range;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [AID_W-1:0] w_head;
  logic             w_pop;
  logic             w_fwd_req;
  logic             w_push;
  logic             w_oor_gnt;

  assign w_in_range = (obi_req_i.a.addr >= ADDR_START) && (obi_req_i.a.addr < ADDR_END);

  // A response with nothing outstanding is stray (e.g. after a reset) and is dropped.
  assign w_pop = hci_rsp_i.r_valid && !w_empty;

  // In-range requests may proceed while the error response is being emitted: only one error can
  // be pending and it always leaves in this cycle, ahead of any HCI response.
  assign w_fwd_req = rst_ni && obi_req_i.req && w_in_range && (!w_full || w_pop);
  assign w_push    = w_fwd_req && hci_rsp_i.gnt;

  // Out-of-range requests wait for a completely drained bridge so responses stay in order.
  assign w_oor_gnt = rst_ni && obi_req_i.req && !w_in_range && w_empty && !r_err_pend;

  obi2hci_id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (AID_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (obi_req_i.a.aid),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head),
    .count_o (w_count)
  );

  always_comb begin
    hci_req_o         = '0;
    hci_req_o.req     = w_fwd_req;
    hci_req_o.add     = obi_req_i.a.addr;
    hci_req_o.wen     = !obi_req_i.a.we;
    hci_req_o.be      = obi_req_i.a.be;
    hci_req_o.data    = obi_req_i.a.wdata;
    hci_req_o.r_ready = 1'b1;
  end

  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = w_push || w_oor_gnt;
    obi_rsp_o.rvalid = w_pop || r_err_pend;
    if (w_pop) begin
      obi_rsp_o.r.rdata = hci_rsp_i.r_data;
      obi_rsp_o.r.rid   = w_head;
    end else if (r_err_pend) begin
      obi_rsp_o.r.rdata = OBI2HCI_ERR_RDATA;
      obi_rsp_o.r.rid   = r_err_aid;
      obi_rsp_o.r.err   = 1'b1;
    end
  end

  assign busy_o = (r_state != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_err_pend <= 1'b0;
      r_err_aid  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_push) begin
            r_state <= ST_FWD;
          end else if (w_oor_gnt) begin
            r_state    <= ST_ERR;
            r_err_pend <= 1'b1;
            r_err_aid  <= obi_req_i.a.aid;
          end
        end
        ST_FWD: begin
          if (w_pop && !w_push && (w_count == CW'(1))) r_state <= ST_IDLE;
        end
        ST_ERR: begin
          r_err_pend <= 1'b0;
          r_state    <= w_push ? ST_FWD : ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_err_pend <= 1'b0;
        end
      endcase
    end
  end

  // HCI must never answer when nothing is outstanding.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(hci_rsp_i.r_valid && w_empty));
    end
  end

endmodule
